// File: rtl/send_recieve_pkg.sv
// Shared types and constants for the bit0/bit1/dt send-receive handshake.
package send_recieve_pkg;

  typedef enum logic [1:0] {IDLE, OFFER, HOLD, RELEASE} state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 255;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bit_receiver_if.sv
// Handshake lines between the sender cells and the receiver, plus the word
// output bus. The master modport belongs to the sender/consumer side.
interface bit_receiver_if import send_recieve_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic                          bit0;
  logic                          bit1;
  logic                          dt;
  logic                          err_clr;
  logic                          ack;
  logic                          senack;
  logic [WIDTH-1:0]              word;
  logic                          word_valid;
  logic [clog2(WIDTH+1)-1:0]     bit_count;
  logic                          proto_err;

  modport master (
    output bit0, bit1, dt, err_clr,
    input  ack, senack, word, word_valid, bit_count, proto_err
  );

  modport slave (
    input  bit0, bit1, dt, err_clr,
    output ack, senack, word, word_valid, bit_count, proto_err
  );

endinterface

// File: rtl/bit_receiver_sync_bit.sv
// Multi-flop synchroniser for one asynchronous input line.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr <= '0;
    else        sr <= {sr[STAGES-2:0], din};
  end

  assign dout = sr[STAGES-1];

endmodule

// File: rtl/bit_receiver.sv
// Receiver side of the bit0/bit1/dt handshake: acknowledges each offered bit,
// shifts it in MSB-first and strobes word_valid when WIDTH bits have arrived.
module bit_receiver import send_recieve_pkg::*; #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  bit_receiver_if.slave   rx
);

  localparam int CW = clog2(WIDTH + 1);
  localparam int TW = clog2(TIMEOUT + 1);

  logic b0s, b1s, dts;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_b0 (.clk(clk), .reset(reset), .din(rx.bit0), .dout(b0s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_b1 (.clk(clk), .reset(reset), .din(rx.bit1), .dout(b1s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_dt (.clk(clk), .reset(reset), .din(rx.dt),   .dout(dts));

  state_t           state, state_nxt;
  logic             lat_bit;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    bit_count;
  logic [TW-1:0]    tmo_cnt;
  logic [WIDTH-1:0] word_q;
  logic             ack_q, senack_q, word_valid_q, proto_err_q;
  logic             err_evt, commit, latch_offer, tmo_hit;

  always_comb begin
    state_nxt   = state;
    err_evt     = 1'b0;
    commit      = 1'b0;
    latch_offer = 1'b0;
    tmo_hit     = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT));
    shreg_nxt   = {shreg[WIDTH-2:0], lat_bit};
    if (tmo_hit) begin
      err_evt   = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if ((b0s && b1s) || dts) begin
            err_evt = 1'b1;
          end else if (b0s || b1s) begin
            latch_offer = 1'b1;
            state_nxt   = OFFER;
          end
        end
        OFFER: begin
          // Sender switching to the opposite line mid-offer is a violation.
          if (lat_bit ? b0s : b1s) begin
            err_evt   = 1'b1;
            state_nxt = IDLE;
          end else if (!b0s && !b1s && !dts) begin
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (b0s || b1s) begin
            err_evt   = 1'b1;
            state_nxt = IDLE;
          end else if (dts) begin
            commit    = 1'b1;
            state_nxt = RELEASE;
          end
        end
        RELEASE: begin
          if (!dts) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      lat_bit      <= 1'b0;
      shreg        <= '0;
      bit_count    <= '0;
      tmo_cnt      <= '0;
      word_q       <= '0;
      ack_q        <= 1'b0;
      senack_q     <= 1'b0;
      word_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state        <= state_nxt;
      ack_q        <= (state_nxt == OFFER);
      senack_q     <= (state_nxt == RELEASE);
      word_valid_q <= 1'b0;
      tmo_cnt      <= (state == IDLE || state_nxt != state) ? '0 : tmo_cnt + 1'b1;
      if (latch_offer) lat_bit <= b1s;
      if (commit) begin
        shreg <= shreg_nxt;
        if (bit_count == CW'(WIDTH - 1)) begin
          word_q       <= shreg_nxt;
          word_valid_q <= 1'b1;
          bit_count    <= '0;
        end else begin
          bit_count <= bit_count + 1'b1;
        end
      end
      // A new error outranks a simultaneous clear.
      if (err_evt)         proto_err_q <= 1'b1;
      else if (rx.err_clr) proto_err_q <= 1'b0;
    end
  end

  assign rx.ack        = ack_q;
  assign rx.senack     = senack_q;
  assign rx.word       = word_q;
  assign rx.word_valid = word_valid_q;
  assign rx.bit_count  = bit_count;
  assign rx.proto_err  = proto_err_q;

endmodule

// File: tb/tb_bit_receiver.sv
// Directed bench for bit_receiver: sender handshakes, word scoreboard, error paths.
module tb_bit_receiver;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   nvalid;
  logic [7:0] exp_q[$];

  bit_receiver_if #(.WIDTH(8)) bus ();

  bit_receiver #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sel: 0=ack 1=senack 2=proto_err
  task automatic wait_for(input string tag, input int sel, input logic val, input int limit);
    logic cur;
    bit   ok;
    ok  = 1'b0;
    cur = 1'bx;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      case (sel)
        0:       cur = bus.ack;
        1:       cur = bus.senack;
        default: cur = bus.proto_err;
      endcase
      ok = (cur === val);
    end
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b (timed out)", tag, cur, val);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    if (b) bus.bit1 = 1'b1;
    else   bus.bit0 = 1'b1;
    wait_for("ack_rise", 0, 1'b1, 20);
    bus.bit0 = 1'b0;
    bus.bit1 = 1'b0;
    wait_for("ack_fall", 0, 1'b0, 20);
    bus.dt = 1'b1;
    wait_for("senack_rise", 1, 1'b1, 20);
    bus.dt = 1'b0;
    wait_for("senack_fall", 1, 1'b0, 20);
  endtask

  task automatic send_word(input logic [7:0] w);
    exp_q.push_back(w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard: each word_valid pulse must match the oldest queued word.
  always @(negedge clk) begin
    if (reset && bus.word_valid === 1'b1) begin
      nvalid++;
      total++;
      if (exp_q.size() == 0) begin
        assert (bus.word_valid === 1'b0) else begin
          bad++;
          $error("FAIL unexpected_valid observed=%0h expected=no_word", bus.word);
        end
      end else begin
        logic [7:0] expw;
        expw = exp_q.pop_front();
        assert (bus.word === expw) else begin
          bad++;
          $error("FAIL word observed=%0h expected=%0h", bus.word, expw);
        end
      end
    end
  end

  initial begin
    logic ack_seen;
    total    = 0;
    bad      = 0;
    nvalid   = 0;
    reset    = 1'b0;
    bus.bit0 = 1'b0;
    bus.bit1 = 1'b0;
    bus.dt   = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack",        32'(bus.ack),        0);
    chk("rst_senack",     32'(bus.senack),     0);
    chk("rst_word",       32'(bus.word),       0);
    chk("rst_word_valid", 32'(bus.word_valid), 0);
    chk("rst_bit_count",  32'(bus.bit_count),  0);
    chk("rst_proto_err",  32'(bus.proto_err),  0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    send_word(8'h00);
    chk("zeros_nvalid",    32'(nvalid),        1);
    chk("zeros_word",      32'(bus.word),      32'h00);
    chk("zeros_bit_count", 32'(bus.bit_count), 0);

    exp_q.push_back(8'hB2);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("mid_bit_count", 32'(bus.bit_count), 3);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (3) @(negedge clk);
    chk("b2_word",      32'(bus.word),      32'hB2);
    chk("b2_bit_count", 32'(bus.bit_count), 0);
    chk("b2_proto_err", 32'(bus.proto_err), 0);

    bus.bit0 = 1'b1;
    bus.bit1 = 1'b1;
    repeat (6) @(negedge clk);
    chk("both_proto_err", 32'(bus.proto_err), 1);
    chk("both_ack",       32'(bus.ack),       0);
    bus.bit0 = 1'b0;
    bus.bit1 = 1'b0;
    repeat (4) @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("clr_proto_err", 32'(bus.proto_err), 0);

    bus.bit0 = 1'b1;
    wait_for("stall_ack_rise", 0, 1'b1, 20);
    chk("stall_no_err_yet", 32'(bus.proto_err), 0);
    wait_for("stall_timeout", 2, 1'b1, 300);
    chk("tmo_ack", 32'(bus.ack), 0);
    bus.bit0 = 1'b0;
    repeat (540) @(negedge clk);
    chk("tmo_idle_ack",    32'(bus.ack),       0);
    chk("tmo_idle_senack", 32'(bus.senack),    0);
    chk("tmo_bit_count",   32'(bus.bit_count), 0);
    chk("tmo_proto_err",   32'(bus.proto_err), 1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("tmo_clr", 32'(bus.proto_err), 0);

    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("pre_rst_bit_count", 32'(bus.bit_count), 3);
    @(negedge clk);
    bus.bit0 = 1'b1;
    wait_for("hold_ack_rise", 0, 1'b1, 20);
    bus.bit0 = 1'b0;
    wait_for("hold_ack_fall", 0, 1'b0, 20);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_bit_count", 32'(bus.bit_count), 0);
    chk("async_rst_word",      32'(bus.word),      0);
    chk("async_rst_ack",       32'(bus.ack),       0);
    chk("async_rst_senack",    32'(bus.senack),    0);
    chk("async_rst_proto_err", 32'(bus.proto_err), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    send_word(8'h3C);
    chk("after_rst_word", 32'(bus.word), 32'h3C);

    ack_seen = 1'b0;
    @(negedge clk);
    #1 bus.bit0 = 1'b1;
    #2 bus.bit0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) ack_seen = 1'b1;
    end
    chk("glitch_ack",       32'(ack_seen),      0);
    chk("glitch_bit_count", 32'(bus.bit_count), 0);
    chk("glitch_proto_err", 32'(bus.proto_err), 0);

    chk("total_valids", 32'(nvalid),       3);
    chk("queue_empty",  32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
